// File: rtl/mesh_link.sv
// Elastic link stage between two mesh nodes, with closed-boundary and
// sink-and-count modes for the outward-facing ports of edge nodes.
module mesh_link #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned MODE       = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    vin,
  output logic                    rout,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    vout,
  input  logic                    rin,
  input  logic                    clr_cnt,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_WIDTH-1:0]    pkt_cnt,
  output logic [CNT_WIDTH-1:0]    drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned MODE_PASS    = 0;
  localparam int unsigned MODE_BLOCK   = 1;
  localparam int unsigned MODE_DISCARD = 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  if (MODE > MODE_DISCARD) begin : g_bad_mode
    $error("mesh_link: MODE %0d is not 0 (PASS), 1 (BLOCK) or 2 (DISCARD)", MODE);
  end

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mesh_link: DEPTH %0d must be a power of two and at least 2", DEPTH);
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_WIDTH'(1);
  endfunction

  // Goes high on the first edge after reset so that edge never accepts a beat.
  logic live;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live <= 1'b0;
    else      live <= 1'b1;
  end

  if (MODE == MODE_PASS) begin : g_pass
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      occ;
    logic [CNT_WIDTH-1:0]  pkt_q;
    logic                  push;
    logic                  pop;

    // Ready depends only on registered state: no rin -> rout path.
    assign rout = live && (occ < LVL_W'(DEPTH));
    assign vout = (occ != '0);
    assign push = vin && rout;
    assign pop  = vout && rin;
    assign dout = vout ? mem[rd_ptr] : '0;

    assign level    = occ;
    assign pkt_cnt  = pkt_q;
    assign drop_cnt = '0;

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   occ <= occ + LVL_W'(1);
          2'b01:   occ <= occ - LVL_W'(1);
          default: occ <= occ;
        endcase
      end
    end

    // Delivered-packet statistics; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)         pkt_q <= '0;
      else if (clr_cnt) pkt_q <= '0;
      else if (pop)     pkt_q <= sat_inc(pkt_q);
    end
  end else if (MODE == MODE_DISCARD) begin : g_discard
    logic [CNT_WIDTH-1:0] drop_q;
    logic                 unused_discard;

    assign rout     = live;
    assign vout     = 1'b0;
    assign dout     = '0;
    assign level    = '0;
    assign pkt_cnt  = '0;
    assign drop_cnt = drop_q;
    assign unused_discard = ^{din, rin};

    // Every offered beat is swallowed and counted.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)              drop_q <= '0;
      else if (clr_cnt)      drop_q <= '0;
      else if (vin && rout)  drop_q <= sat_inc(drop_q);
    end
  end else begin : g_block
    logic unused_block;

    assign rout     = 1'b0;
    assign vout     = 1'b0;
    assign dout     = '0;
    assign level    = '0;
    assign pkt_cnt  = '0;
    assign drop_cnt = '0;
    assign unused_block = ^{din, vin, rin, clr_cnt, live};
  end

endmodule

// File: tb/tb_mesh_link.sv
// Randomised and directed bench for mesh_link: PASS (DEPTH 4 and 2), DISCARD
// and BLOCK instances share one stimulus stream and are checked every cycle.
module tb_mesh_link;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          vin;
  logic          rin;
  logic          clr_cnt;

  logic          p4_rout, p4_vout;
  logic [DW-1:0] p4_dout;
  logic [2:0]    p4_level;
  logic [15:0]   p4_pkt, p4_drop;

  logic          p2_rout, p2_vout;
  logic [DW-1:0] p2_dout;
  logic [1:0]    p2_level;
  logic [15:0]   p2_pkt, p2_drop;

  logic          ds_rout, ds_vout;
  logic [DW-1:0] ds_dout;
  logic [1:0]    ds_level;
  logic [3:0]    ds_pkt, ds_drop;

  logic          bk_rout, bk_vout;
  logic [DW-1:0] bk_dout;
  logic [1:0]    bk_level;
  logic [15:0]   bk_pkt, bk_drop;

  int tests = 0;
  int fails = 0;

  // Reference model: queues of accepted packets plus plain integer counters.
  logic [DW-1:0] q4[$];
  logic [DW-1:0] q2[$];
  bit            m_live;
  int            pkt4, pkt2, drop_m;
  bit            acc4;

  always #5 clk = ~clk;

  mesh_link #(.DATA_WIDTH(DW), .DEPTH(4), .MODE(0), .CNT_WIDTH(16)) u_p4 (
    .clk(clk), .rst(rst), .din(din), .vin(vin), .rout(p4_rout), .dout(p4_dout),
    .vout(p4_vout), .rin(rin), .clr_cnt(clr_cnt), .level(p4_level),
    .pkt_cnt(p4_pkt), .drop_cnt(p4_drop));

  mesh_link #(.DATA_WIDTH(DW), .DEPTH(2), .MODE(0), .CNT_WIDTH(16)) u_p2 (
    .clk(clk), .rst(rst), .din(din), .vin(vin), .rout(p2_rout), .dout(p2_dout),
    .vout(p2_vout), .rin(rin), .clr_cnt(clr_cnt), .level(p2_level),
    .pkt_cnt(p2_pkt), .drop_cnt(p2_drop));

  mesh_link #(.DATA_WIDTH(DW), .DEPTH(2), .MODE(2), .CNT_WIDTH(4)) u_ds (
    .clk(clk), .rst(rst), .din(din), .vin(vin), .rout(ds_rout), .dout(ds_dout),
    .vout(ds_vout), .rin(rin), .clr_cnt(clr_cnt), .level(ds_level),
    .pkt_cnt(ds_pkt), .drop_cnt(ds_drop));

  mesh_link #(.DATA_WIDTH(DW), .DEPTH(2), .MODE(1), .CNT_WIDTH(16)) u_bk (
    .clk(clk), .rst(rst), .din(din), .vin(vin), .rout(bk_rout), .dout(bk_dout),
    .vout(bk_vout), .rin(rin), .clr_cnt(clr_cnt), .level(bk_level),
    .pkt_cnt(bk_pkt), .drop_cnt(bk_drop));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q4.delete();
    q2.delete();
    m_live = 1'b0;
    pkt4   = 0;
    pkt2   = 0;
    drop_m = 0;
    acc4   = 1'b0;
  endtask

  // Apply one rising edge to the model using the inputs seen at that edge.
  task automatic model_edge();
    bit push, pop;
    acc4 = 1'b0;
    if (!rst) begin
      model_reset();
    end else begin
      pop  = (q4.size() != 0) && rin;
      push = m_live && vin && (q4.size() < 4);
      if (pop) begin q4.delete(0); if (pkt4 < 65535) pkt4++; end
      if (push) q4.push_back(din);
      acc4 = push;

      pop  = (q2.size() != 0) && rin;
      push = m_live && vin && (q2.size() < 2);
      if (pop) begin q2.delete(0); if (pkt2 < 65535) pkt2++; end
      if (push) q2.push_back(din);

      if (m_live && vin && drop_m < 15) drop_m++;
      if (clr_cnt) begin pkt4 = 0; pkt2 = 0; drop_m = 0; end
      m_live = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("p4_rout",  64'(p4_rout),  64'(m_live && q4.size() < 4));
    chk("p4_vout",  64'(p4_vout),  64'(q4.size() != 0));
    chk("p4_level", 64'(p4_level), 64'(q4.size()));
    chk("p4_pkt",   64'(p4_pkt),   64'(pkt4));
    chk("p4_drop",  64'(p4_drop),  64'(0));
    if (q4.size() != 0) chk("p4_dout", 64'(p4_dout), 64'(q4[0]));

    chk("p2_rout",  64'(p2_rout),  64'(m_live && q2.size() < 2));
    chk("p2_vout",  64'(p2_vout),  64'(q2.size() != 0));
    chk("p2_level", 64'(p2_level), 64'(q2.size()));
    chk("p2_pkt",   64'(p2_pkt),   64'(pkt2));
    if (q2.size() != 0) chk("p2_dout", 64'(p2_dout), 64'(q2[0]));

    if (!rst) begin
      chk("p4_dout_rst", 64'(p4_dout), 64'(0));
      chk("p2_dout_rst", 64'(p2_dout), 64'(0));
    end

    chk("ds_rout",  64'(ds_rout),  64'(m_live));
    chk("ds_vout",  64'(ds_vout),  64'(0));
    chk("ds_dout",  64'(ds_dout),  64'(0));
    chk("ds_level", 64'(ds_level), 64'(0));
    chk("ds_pkt",   64'(ds_pkt),   64'(0));
    chk("ds_drop",  64'(ds_drop),  64'(drop_m));

    chk("bk_outs", 64'({bk_rout, bk_vout, bk_dout, bk_level, bk_pkt, bk_drop}), 64'(0));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    bit got;

    // Reset held with a packet on offer; release, then the first edge only arms.
    rst = 1'b0; vin = 1'b1; din = 32'hA5; rin = 1'b1; clr_cnt = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("first_edge_level", 64'(p4_level), 64'(0));
    chk("first_edge_rout",  64'(p4_rout),  64'(1));
    step();
    chk("lat_vout", 64'(p4_vout), 64'(1));
    chk("lat_dout", 64'(p4_dout), 64'(32'hA5));

    // Fill with downstream stalled, hold a fifth packet, then drain in order.
    vin = 1'b0;
    repeat (3) step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    rin = 1'b0; vin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 32'h10 + 32'(i);
      step();
    end
    chk("fill_level", 64'(p4_level), 64'(4));
    chk("fill_rout",  64'(p4_rout),  64'(0));
    din = 32'h14;
    repeat (2) step();
    chk("fill_held_level", 64'(p4_level), 64'(4));
    rin = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = acc4;
    end
    if (!got) chk("fill_accept_timeout", 64'(0), 64'(1));
    vin = 1'b0;
    repeat (6) step();
    chk("fill_pkt", 64'(p4_pkt), 64'(5));

    // Streaming with an incrementing payload.
    vin = 1'b1; rin = 1'b1;
    for (int i = 0; i < 100; i++) begin
      din = 32'h1000 + 32'(i);
      step();
      if (i > 0) chk("stream_p2_level", 64'(p2_level <= 2'd1), 64'(1));
    end

    // Discard counter saturation, then clear with a same-cycle offer.
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    repeat (20) step();
    chk("disc_sat", 64'(ds_drop), 64'(15));
    clr_cnt = 1'b1;
    step();
    chk("disc_clr", 64'(ds_drop), 64'(0));
    clr_cnt = 1'b0;
    step();
    chk("disc_after_clr", 64'(ds_drop), 64'(1));

    // Build level 3 / pkt_cnt 7, then pulse reset between edges.
    vin = 1'b0;
    repeat (4) step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    vin = 1'b1;
    for (int i = 0; i < 7; i++) begin
      din = $urandom;
      step();
    end
    vin = 1'b0;
    step();
    rin = 1'b0; vin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 32'hC0 + 32'(i);
      step();
    end
    chk("midrst_pre_level", 64'(p4_level), 64'(3));
    chk("midrst_pre_pkt",   64'(p4_pkt),   64'(7));
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("midrst_level", 64'(p4_level), 64'(0));
    chk("midrst_vout",  64'(p4_vout),  64'(0));
    #3;
    rst = 1'b1;

    // Random traffic; any stale packet would disagree with the empty model.
    for (int i = 0; i < 300; i++) begin
      vin     = ($urandom_range(0, 3) != 0);
      rin     = ($urandom_range(0, 1) != 0);
      din     = $urandom;
      clr_cnt = ($urandom_range(0, 31) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mesh_link.md
# mesh_link

Parametrised inter-node link for the neuromorphic NoC mesh. It replaces the direct wire between one node's output port (dout/vout/rin) and a neighbour's input port (din/vin/rout) with an elastic FIFO stage. It also has a boundary mode, so edge ports can either block or sink-and-count packets instead of being hard-tied. One instance sits on each directed link of the mesh, including the outward-facing ports of edge nodes.

## Interface

Parameters:
- DATA_WIDTH, 32, packet width in bits.
- DEPTH, 2, FIFO entries; power of two, at least 2.
- MODE, 0, link behaviour: 0 = PASS (live link), 1 = BLOCK (closed boundary), 2 = DISCARD (boundary sink).
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk, input, 1, single clock; all state on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- din, input, DATA_WIDTH, packet from the upstream node's dout.
- vin, input, 1, upstream valid (upstream vout).
- rout, output, 1, ready to upstream (drives upstream rin).
- dout, output, DATA_WIDTH, packet to the downstream node's din.
- vout, output, 1, valid to downstream (drives downstream vin).
- rin, input, 1, downstream ready (downstream rout).
- clr_cnt, input, 1, synchronous clear of pkt_cnt and drop_cnt.
- level, output, $clog2(DEPTH)+1, current FIFO occupancy.
- pkt_cnt, output, CNT_WIDTH, packets delivered downstream.
- drop_cnt, output, CNT_WIDTH, packets discarded (DISCARD mode only).

## Operation

- **Handshake.** A beat transfers on a rising edge when valid and ready are both high. Upstream side: vin && rout. Downstream side: vout && rin.
- **PASS mode, storage.** DEPTH-entry circular FIFO with wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap at DEPTH−1→0) and an occupancy counter.
- **PASS mode, ready/valid.**
  - rout = (level < DEPTH), derived from registers only. There is no combinational path from rin to rout.
  - vout = (level != 0).
  - dout = mem[rd_ptr], first-word-fall-through. dout is don't-care when vout = 0; the bench checks it only under vout.
- **Push.** On an upstream beat, write mem[wr_ptr] and advance wr_ptr.
- **Pop.** On a downstream beat, advance rd_ptr.
- **Level update.**
  - Push only: level +1.
  - Pop only: level −1.
  - Push and pop together: level unchanged.
  - When full, rout = 0, so no push occurs even if a pop happens in the same cycle. There is no full-bypass.
- **Packet counter.** pkt_cnt increments on each downstream beat.
- **BLOCK mode.**
  - rout = 0, vout = 0, dout = 0.
  - level, pkt_cnt and drop_cnt are held at 0.
  - FIFO storage may be optimised away.
- **DISCARD mode.**
  - rout = 1, vout = 0, dout = 0, level = 0.
  - Each cycle with vin = 1 increments drop_cnt. Packet contents are ignored.
- **Counter rules.**
  - pkt_cnt and drop_cnt saturate at all-ones and never wrap.
  - clr_cnt = 1 forces both to 0 on the next edge. Clear wins over a same-cycle increment.
- **Invalid MODE.** A MODE value outside 0..2 is an elaboration error, raised by a generate-time $error.

## Timing

- **Reset.** rst low asynchronously forces, in every mode:
  - rout = 0, vout = 0, dout = 0 (dout through an output mux gated by vout);
  - level = 0, pkt_cnt = 0, drop_cnt = 0;
  - pointers = 0.
- **First cycle after reset.** On the first edge with rst high:
  - rout goes to 1 (PASS, DISCARD) or stays 0 (BLOCK);
  - no transfer is accepted on that edge.
  - This is implemented with a one-bit registered "live" flag.
- **Reset mid-operation.** All queued packets are lost and counters clear. There is no partial state.
- **Latency (PASS).** A packet accepted at edge N presents vout = 1 with that data during cycle N+1. It can be delivered at edge N+1. Minimum latency: 1 cycle.
- **Throughput.** One packet per cycle sustained for DEPTH ≥ 2 with rin held high.
- **Backpressure.** With rin = 0, exactly DEPTH packets are accepted. rout falls in the cycle after the DEPTH-th accept. A single pop re-raises rout in the following cycle.
- **Ordering.** Strict FIFO. No reordering and no duplication.

## Test plan

- **Reset and first cycle.** Hold rst low, then release, with vin = 1 and din = 32'hA5 held throughout -> all outputs 0 during reset; no accept on the first edge after release; accept on the second edge; vout = 1 with dout = 32'hA5 one cycle later.
- **Fill and drain** (DEPTH=4, PASS). rin = 0; push 0x10, 0x11, 0x12, 0x13, 0x14 on consecutive cycles -> first four accepted, level = 4, rout = 0, 0x14 held upstream. Then raise rin -> 0x10–0x14 delivered in order and pkt_cnt = 5.
- **Streaming** (DEPTH=2). vin = rin = 1 for 100 cycles with an incrementing payload -> level never exceeds 1 after the start, 1 packet per cycle, payload order intact. Then wrap-around: ptrs cross DEPTH−1→0 at least 25 times.
- **DISCARD saturation** (CNT_WIDTH=4). vin = 1 for 20 cycles -> rout = 1 throughout, vout = 0, drop_cnt saturates at 15. Then pulse clr_cnt while vin = 1 -> drop_cnt = 0 on that edge, then increments to 1.
- **BLOCK mode.** vin = 1 with random din for 50 cycles -> rout, vout, level and both counters stay 0.
- **Reset mid-operation** (PASS, DEPTH=4). With level = 3 and pkt_cnt = 7, assert rst for a half-cycle between edges -> outputs clear immediately without waiting for an edge; after release, no stale packet ever appears on dout.
